// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer.
//   DATA_W / OP_W : operand/result width and opcode width
//   OP_*          : opcodes understood by the combinational ALU
//   state_e       : sequencer FSM states (encoding visible on the debug LEDs)
//   op_is_valid() : true for the opcodes the ALU implements
package alu_operand_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        StWaitA  = 3'd0,
        StWaitB  = 3'd1,
        StWaitOp = 3'd2,
        StExec   = 3'd3,
        StDone   = 3'd4
    } state_e;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board/ALU-facing bus of the operand sequencer.
//   master : board I/O + ALU side (drives switches, buttons, ALU result)
//   slave  : the sequencer (drives ALU operands, result, status)
//   i_sw, i_btn_a/b/op : shared switch bus and load buttons (asynchronous)
//   i_alu_z            : combinational ALU result
//   o_alu_a/b/op       : registered ALU operands and opcode
//   o_result, o_valid, o_err, o_state : held result, status flags, FSM state
interface alu_operand_sequencer_if;
    import alu_operand_sequencer_pkg::*;

    logic [DATA_W-1:0] i_sw;
    logic              i_btn_a;
    logic              i_btn_b;
    logic              i_btn_op;
    logic [DATA_W-1:0] i_alu_z;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [OP_W-1:0]   o_alu_op;
    logic [DATA_W-1:0] o_result;
    logic              o_valid;
    logic              o_err;
    logic [2:0]        o_state;

    modport master (
        output i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_z,
        input  o_alu_a, o_alu_b, o_alu_op, o_result, o_valid, o_err, o_state
    );

    modport slave (
        input  i_sw, i_btn_a, i_btn_b, i_btn_op, i_alu_z,
        output o_alu_a, o_alu_b, o_alu_op, o_result, o_valid, o_err, o_state
    );

endinterface

// File: rtl/alu_operand_sequencer_btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
//   clk, reset : system clock, asynchronous active-high reset
//   btn        : raw asynchronous button level
//   pulse      : one-cycle pulse, high in the cycle after the 2nd sync edge
module alu_operand_sequencer_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A held button gives one pulse; a re-press needs the level to drop through the sync chain.
    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequences a combinational ALU from shared board inputs: A, B and opcode are captured
// from the switch bus on three button presses, one EXEC cycle runs, and Z is held.
//   clk   : system clock (rising edge)
//   reset : asynchronous active-high reset; abandons any sequence in progress
//   bus   : alu_operand_sequencer_if.slave (switches, buttons, ALU operands/result, status)
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    alu_operand_sequencer_if.slave bus
);

    logic pulse_a;
    logic pulse_b;
    logic pulse_op;

    alu_operand_sequencer_btn_edge u_btn_a (
        .clk  (clk),
        .reset(reset),
        .btn  (bus.i_btn_a),
        .pulse(pulse_a)
    );

    alu_operand_sequencer_btn_edge u_btn_b (
        .clk  (clk),
        .reset(reset),
        .btn  (bus.i_btn_b),
        .pulse(pulse_b)
    );

    alu_operand_sequencer_btn_edge u_btn_op (
        .clk  (clk),
        .reset(reset),
        .btn  (bus.i_btn_op),
        .pulse(pulse_op)
    );

    state_e            state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] result_q;
    logic              valid_q;
    logic              err_q;

    // Pulses not expected by the current state are dropped, never queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StWaitA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StWaitA: begin
                    if (pulse_a) begin
                        a_q     <= bus.i_sw;
                        state_q <= StWaitB;
                    end
                end
                StWaitB: begin
                    if (pulse_b) begin
                        b_q     <= bus.i_sw;
                        state_q <= StWaitOp;
                    end
                end
                StWaitOp: begin
                    if (pulse_op) begin
                        op_q    <= bus.i_sw[OP_W-1:0];
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    result_q <= op_is_valid(op_q) ? bus.i_alu_z : '0;
                    err_q    <= ~op_is_valid(op_q);
                    valid_q  <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    // Result stays on the LEDs until the next EXEC; only the flags clear.
                    if (pulse_a) begin
                        a_q     <= bus.i_sw;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= StWaitB;
                    end
                end
                default: state_q <= StWaitA;
            endcase
        end
    end

    assign bus.o_alu_a  = a_q;
    assign bus.o_alu_b  = b_q;
    assign bus.o_alu_op = op_q;
    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_err    = err_q;
    assign bus.o_state  = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed scenarios then random presses,
// checked against a press-level model of the sequencer and a behavioural ALU.
module tb_alu_operand_sequencer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_operand_sequencer_if bus ();

    alu_operand_sequencer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unsupported opcodes return a non-zero junk value.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return 8'($signed(a) >>> b);
            6'b000010: return a >> b;
            default:   return 8'hA5;
        endcase
    endfunction

    function automatic bit ref_valid(input logic [5:0] op);
        return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b100110, 6'b100111, 6'b000011, 6'b000010};
    endfunction

    always_comb bus.i_alu_z = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    // Press-level model: state numbers 0..4 = wait A, wait B, wait op, exec, done.
    logic [7:0] m_a, m_b, m_res;
    logic [5:0] m_op;
    logic       m_valid, m_err;
    logic [2:0] m_state;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_valid = 0; m_err = 0; m_state = 0;
    endtask

    // mask bit0 = A, bit1 = B, bit2 = op; a completed op press includes the exec cycle.
    task automatic model_press(input logic [2:0] mask, input logic [7:0] sw);
        if ((m_state == 0 || m_state == 4) && mask[0]) begin
            m_a = sw;
            m_valid = 0;
            m_err = 0;
            m_state = 1;
        end else if (m_state == 1 && mask[1]) begin
            m_b = sw;
            m_state = 2;
        end else if (m_state == 2 && mask[2]) begin
            m_op = sw[5:0];
            m_valid = 1;
            m_err = !ref_valid(m_op);
            m_res = ref_valid(m_op) ? alu_ref(m_a, m_b, m_op) : 8'h00;
            m_state = 4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a"},      32'(bus.o_alu_a),  32'(m_a));
        chk({tag, ".b"},      32'(bus.o_alu_b),  32'(m_b));
        chk({tag, ".op"},     32'(bus.o_alu_op), 32'(m_op));
        chk({tag, ".result"}, 32'(bus.o_result), 32'(m_res));
        chk({tag, ".valid"},  32'(bus.o_valid),  32'(m_valid));
        chk({tag, ".err"},    32'(bus.o_err),    32'(m_err));
        chk({tag, ".state"},  32'(bus.o_state),  32'(m_state));
    endtask

    task automatic set_btns(input logic [2:0] mask);
        bus.i_btn_a  = mask[0];
        bus.i_btn_b  = mask[1];
        bus.i_btn_op = mask[2];
    endtask

    // Hold 4 cycles, release 3 cycles (enough to re-arm the edge detector), then check.
    task automatic press(input string tag, input logic [2:0] mask, input logic [7:0] sw);
        @(posedge clk);
        #1;
        bus.i_sw = sw;
        set_btns(mask);
        repeat (4) @(posedge clk);
        #1;
        set_btns(3'b000);
        repeat (3) @(posedge clk);
        model_press(mask, sw);
        @(negedge clk);
        check_all(tag);
    endtask

    logic [5:0] valid_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.i_sw = 8'h00;
        set_btns(3'b000);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: A with load timing, B, then SRL op with valid timing.
        @(posedge clk);
        #1;
        bus.i_sw = 8'hB4;
        set_btns(3'b001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1.a_not_yet", 32'(bus.o_state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1.a_loaded_3rd_edge", 32'(bus.o_state), 32'd1);
        chk("t1.a_value", 32'(bus.o_alu_a), 32'hB4);
        @(posedge clk);
        #1 set_btns(3'b000);
        repeat (3) @(posedge clk);
        model_press(3'b001, 8'hB4);
        press("t1.b", 3'b010, 8'h02);
        @(posedge clk);
        #1;
        bus.i_sw = 8'h02;
        set_btns(3'b100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1.exec_state", 32'(bus.o_state), 32'd3);
        chk("t1.exec_not_valid", 32'(bus.o_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1.done_valid", 32'(bus.o_valid), 32'd1);
        chk("t1.done_result", 32'(bus.o_result), 32'h2D);
        chk("t1.done_err", 32'(bus.o_err), 32'd0);
        chk("t1.done_state", 32'(bus.o_state), 32'd4);
        #1 set_btns(3'b000);
        repeat (3) @(posedge clk);
        model_press(3'b100, 8'h02);
        @(negedge clk);
        check_all("t1.end");

        // 2: reload A from DONE keeps the old result, then ADD.
        press("t2.a", 3'b001, 8'h0F);
        chk("t2.result_kept", 32'(bus.o_result), 32'h2D);
        press("t2.b", 3'b010, 8'h01);
        press("t2.op", 3'b100, 8'h20);
        chk("t2.add_result", 32'(bus.o_result), 32'h10);

        // 3: B/op in wait-A are ignored.
        press("t3.a0", 3'b001, 8'h33);
        press("t3.b0", 3'b010, 8'h44);
        press("t3.op0", 3'b100, 8'h27);
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        press("t3.ignored", 3'b110, 8'h55);
        chk("t3.state0", 32'(bus.o_state), 32'd0);
        press("t3.a", 3'b001, 8'h55);

        // 4: holding A for 20 cycles loads once; later switch changes are not taken.
        press("t4.b", 3'b010, 8'h07);
        press("t4.op", 3'b100, 8'h26);
        @(posedge clk);
        #1;
        bus.i_sw = 8'h9C;
        set_btns(3'b001);
        repeat (8) @(posedge clk);
        #1 bus.i_sw = 8'h11;
        repeat (12) @(posedge clk);
        #1 set_btns(3'b000);
        repeat (3) @(posedge clk);
        model_press(3'b001, 8'h9C);
        @(negedge clk);
        check_all("t4.hold");

        // 5: unsupported opcode.
        press("t5.b", 3'b010, 8'h05);
        press("t5.op", 3'b100, 8'h3F);
        chk("t5.err", 32'(bus.o_err), 32'd1);
        chk("t5.result_zero", 32'(bus.o_result), 32'd0);
        press("t5.clear", 3'b001, 8'h80);
        chk("t5.err_cleared", 32'(bus.o_err), 32'd0);

        // 6: async reset in wait-op, then an op press is ignored.
        press("t6.b", 3'b010, 8'h03);
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        press("t6.a", 3'b001, 8'hFF);
        press("t6.b2", 3'b010, 8'h03);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        @(posedge clk);
        #1 reset = 1'b0;
        press("t6.op_ignored", 3'b100, 8'h02);

        // Random presses, including simultaneous and out-of-order buttons.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] mask;
            logic [7:0] sw;
            mask = 3'($urandom_range(1, 7));
            sw = 8'($urandom);
            if (mask[2] && $urandom_range(0, 3) != 0)
                sw = {sw[7:6], valid_ops[$urandom_range(0, 7)]};
            press("rand", mask, sw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
